// File: rtl/data_mem_responder.sv
// data_mem_responder: pointer-addressed byte RAM responder with wait states and a valid/ready response.
// Optional feature macro: MEM_ADDR_BOUNDS_CHECK_EN (flag addresses >= MEM_DEPTH as errors instead of wrapping).
module data_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [3:0]        req_sel,
    input  logic [15:0]       x_ptr,
    input  logic [15:0]       y_ptr,
    input  logic [15:0]       z_ptr,
    input  logic [15:0]       stack_ptr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rsp_err
);
    localparam int ADDR_BITS = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [15:0]         r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_sel_err;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic [15:0]          w_addr;
    logic                 w_sel_err;
    logic [15:0]          w_hi_bits;
    logic                 w_oob;
    logic                 w_err;
    logic                 w_access;
    logic                 w_ram_we;
    logic                 w_rd_ok;
    logic [ADDR_BITS-1:0] w_idx;

    // Pointer mux is a bitwise OR so a multi-hot select still yields a defined (but flagged) address.
    assign w_addr    = ({16{req_sel[0]}} & x_ptr) | ({16{req_sel[1]}} & y_ptr)
                     | ({16{req_sel[2]}} & z_ptr) | ({16{req_sel[3]}} & stack_ptr);
    assign w_sel_err = (req_sel == 4'b0000) || ((req_sel & (req_sel - 4'd1)) != 4'b0000);
    assign w_hi_bits = r_addr >> ADDR_BITS;
    assign w_idx     = r_addr[ADDR_BITS-1:0];

`ifdef MEM_ADDR_BOUNDS_CHECK_EN
    assign w_oob = |w_hi_bits;
`else
    logic w_unused_hi;
    assign w_unused_hi = |w_hi_bits;
    assign w_oob       = 1'b0;
`endif

    assign w_err    = r_sel_err | w_oob;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_ram_we = w_access && r_write && !w_err;
    assign w_rd_ok  = !r_write && !w_err;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rd_data   = r_rd_data;
    assign rsp_err   = r_rsp_err;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (w_ram_we)
            r_mem[w_idx] <= r_wdata;
    end

    // Request/response FSM; an async reset drops any in-flight request before its access edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 16'd0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_sel_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rd_data   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_addr      <= w_addr;
                        r_write     <= req_write;
                        r_wdata     <= wr_data;
                        r_sel_err   <= w_sel_err;
                        r_cnt       <= 4'(WAIT_STATES);
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rd_data   <= w_rd_ok ? r_mem[w_idx] : '0;
                        r_rsp_err   <= w_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
